mem_responder: RTL and testbench

- Memory-side slave that answers the multicycle controller's MemRead/MemWrite strobes.
- Holds a 2^ADDR_W x DATA_W storage array and returns read data or commits write data after a parameterised latency.
- Signals completion with a one-cycle ready pulse.
- Sits between the datapath address/data buses and the controller, so the controller can stall fetch, load and store cycles on ready.

---
 rtl/mem_responder.sv | 179 +++++++++++++++++
 tb/tb_mem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side slave for a multicycle controller.
// Accepts one MemRead/MemWrite request at a time, completes it after a
// parameterised latency and reports completion with a one-cycle ready pulse.
// Optional build macro MEM_RESP_STATS_EN adds saturating read/write counters
// (rd_count, wr_count).
module mem_responder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] RD_CNT   = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_CNT   = CNT_W'(WR_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              op_wr_r;
    logic              err_r;

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Storage array: commit a latched legal write on the edge that raises ready
    always_ff @(posedge clock) begin
        if (reset && (state_r == ST_RESP) && op_wr_r && !err_r) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

    // Request FSM with registered ready/busy/err/rdata outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            addr_r  <= '0;
            wdata_r <= '0;
            op_wr_r <= 1'b0;
            err_r   <= 1'b0;
            rdata   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (MemRead ^ MemWrite) begin
                        addr_r  <= addr;
                        wdata_r <= wdata;
                        op_wr_r <= MemWrite;
                        err_r   <= 1'b0;
                        busy    <= 1'b1;
                        if (MemWrite) begin
                            cnt_r   <= WR_CNT;
                            state_r <= (WR_LAT > 1) ? ST_WAIT : ST_RESP;
                        end else begin
                            cnt_r   <= RD_CNT;
                            state_r <= (RD_LAT > 1) ? ST_WAIT : ST_RESP;
                        end
                    end else if (MemRead && MemWrite) begin
                        // Illegal request: answer at once with err, touch nothing
                        err_r   <= 1'b1;
                        op_wr_r <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= ST_RESP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_RESP;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    err   <= err_r;
                    if (!err_r && !op_wr_r) begin
                        rdata <= mem_r[addr_r];
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_RESP_STATS_EN
    logic rd_hit_s;
    logic wr_hit_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Flag the edge that moves a legal read or write into RESP
    always_comb begin
        rd_hit_s = 1'b0;
        wr_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((MemRead ^ MemWrite) &&
                    (MemWrite ? (WR_LAT == 1) : (RD_LAT == 1))) begin
                    rd_hit_s = MemRead;
                    wr_hit_s = MemWrite;
                end else begin
                    rd_hit_s = 1'b0;
                    wr_hit_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_ONE) begin
                    rd_hit_s = !op_wr_r && !err_r;
                    wr_hit_s = op_wr_r && !err_r;
                end else begin
                    rd_hit_s = 1'b0;
                    wr_hit_s = 1'b0;
                end
            end
            default: begin
                rd_hit_s = 1'b0;
                wr_hit_s = 1'b0;
            end
        endcase
    end

    // Saturating transaction counters
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else begin
            if (rd_hit_s) begin
                rd_count <= sat_inc(rd_count);
            end
            if (wr_hit_s) begin
                wr_count <= sat_inc(wr_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances with different read/write
// latencies, driven by directed and randomized transactions and checked
// against a behavioural memory model.
module tb_mem_responder;

    logic       clock;
    logic       reset     [3];
    logic       mem_read  [3];
    logic       mem_write [3];
    logic [7:0] addr      [3];
    logic [7:0] wdata     [3];
    logic [7:0] rdata     [3];
    logic       ready     [3];
    logic       busy      [3];
    logic       err       [3];
`ifdef MEM_RESP_STATS_EN
    logic [15:0] rd_count [3];
    logic [15:0] wr_count [3];
`endif

    // Reference model state
    logic [7:0] mdl_mem   [3][256];
    logic [7:0] mdl_rdata [3];
    int         mdl_rd    [3];
    int         mdl_wr    [3];

    int n_chk  = 0;
    int n_pass = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .DATA_W(8),
            .ADDR_W(8),
            .RD_LAT(g == 0 ? 2 : (g == 1 ? 1 : 4)),
            .WR_LAT(g == 0 ? 3 : (g == 1 ? 1 : 2))
        ) u_dut (
            .clock   (clock),
            .reset   (reset[g]),
            .MemRead (mem_read[g]),
            .MemWrite(mem_write[g]),
            .addr    (addr[g]),
            .wdata   (wdata[g]),
            .rdata   (rdata[g]),
            .ready   (ready[g]),
            .busy    (busy[g]),
            .err     (err[g])
`ifdef MEM_RESP_STATS_EN
            ,
            .rd_count(rd_count[g]),
            .wr_count(wr_count[g])
`endif
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int rl(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int wl(input int d);
        case (d)
            0:       return 3;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction; strobes are dropped right after acceptance
    task automatic do_txn(input int d, input bit rd, input bit wr,
                          input logic [7:0] a, input logic [7:0] wd);
        int lat;
        int n;
        int bcnt;
        bit ill;
        ill  = rd && wr;
        lat  = ill ? 1 : (wr ? wl(d) : rl(d));
        n    = 0;
        bcnt = 0;
        @(negedge clock);
        mem_read[d]  = rd;
        mem_write[d] = wr;
        addr[d]      = a;
        wdata[d]     = wd;
        @(posedge clock);
        @(negedge clock);
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
        addr[d]      = 8'($urandom);
        wdata[d]     = 8'($urandom);
        while (!ready[d] && n < 20) begin
            if (busy[d]) bcnt++;
            @(posedge clock);
            @(negedge clock);
            n++;
        end
        if (ill) begin
            // no array or rdata change
        end else if (wr) begin
            mdl_mem[d][a] = wd;
            mdl_wr[d]++;
        end else begin
            mdl_rdata[d] = mdl_mem[d][a];
            mdl_rd[d]++;
        end
        chk($sformatf("d%0d latency a=%0h", d, a), n, lat);
        chk($sformatf("d%0d busy_cycles", d), bcnt, lat);
        chk($sformatf("d%0d busy_at_ready", d), {31'd0, busy[d]}, 32'd0);
        chk($sformatf("d%0d err", d), {31'd0, err[d]}, {31'd0, ill});
        chk($sformatf("d%0d rdata a=%0h", d, a), {24'd0, rdata[d]}, {24'd0, mdl_rdata[d]});
        @(posedge clock);
        @(negedge clock);
        chk($sformatf("d%0d ready_single", d), {31'd0, ready[d]}, 32'd0);
    endtask

    task automatic rst_dut(input int d);
        @(negedge clock);
        reset[d] = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset[d] = 1'b1;
        mdl_rdata[d] = 8'd0;
        mdl_rd[d] = 0;
        mdl_wr[d] = 0;
    endtask

    initial begin
        logic [7:0] a;
        int op;
        for (int d = 0; d < 3; d++) begin
            reset[d] = 1'b0; mem_read[d] = 1'b0; mem_write[d] = 1'b0;
            addr[d] = 8'd0; wdata[d] = 8'd0;
            mdl_rdata[d] = 8'd0; mdl_rd[d] = 0; mdl_wr[d] = 0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d reset rdata", d), {24'd0, rdata[d]}, 32'd0);
            chk($sformatf("d%0d reset ready", d), {31'd0, ready[d]}, 32'd0);
            chk($sformatf("d%0d reset busy", d), {31'd0, busy[d]}, 32'd0);
            chk($sformatf("d%0d reset err", d), {31'd0, err[d]}, 32'd0);
            reset[d] = 1'b1;
        end

        // Fill a known address window on every instance
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 64; i++) do_txn(d, 1'b0, 1'b1, 8'(i), 8'($urandom));

        // Reset in the middle of a WR_LAT=3 write aborts it
        do_txn(0, 1'b0, 1'b1, 8'h10, 8'h55);
        @(negedge clock);
        mem_write[0] = 1'b1; addr[0] = 8'h10; wdata[0] = 8'hAA;
        @(posedge clock);
        @(negedge clock);
        mem_write[0] = 1'b0;
        reset[0] = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("mid-write reset rdata", {24'd0, rdata[0]}, 32'd0);
        chk("mid-write reset ready", {31'd0, ready[0]}, 32'd0);
        chk("mid-write reset busy", {31'd0, busy[0]}, 32'd0);
        chk("mid-write reset err", {31'd0, err[0]}, 32'd0);
        reset[0] = 1'b1;
        mdl_rdata[0] = 8'd0; mdl_rd[0] = 0; mdl_wr[0] = 0;
        do_txn(0, 1'b1, 1'b0, 8'h10, 8'h00);

        // Write then read, plus latency sweep on RD_LAT=1 and RD_LAT=4
        do_txn(0, 1'b0, 1'b1, 8'h20, 8'h5C);
        do_txn(0, 1'b1, 1'b0, 8'h20, 8'h00);
        do_txn(1, 1'b1, 1'b0, 8'h00, 8'h00);
        do_txn(2, 1'b1, 1'b0, 8'h00, 8'h00);

        // Illegal request leaves array and rdata untouched
        for (int d = 0; d < 3; d++) begin
            do_txn(d, 1'b1, 1'b0, 8'h05, 8'h00);
            do_txn(d, 1'b1, 1'b1, 8'h30, 8'hFF);
            do_txn(d, 1'b1, 1'b0, 8'h30, 8'h00);
        end

        // Held read strobe on RD_LAT=2: a pulse every 3 cycles
        @(negedge clock);
        mem_read[0] = 1'b1; addr[0] = 8'h07;
        mdl_rdata[0] = mdl_mem[0][7];
        for (int i = 1; i <= 12; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("held ready cyc%0d", i), {31'd0, ready[0]}, {31'd0, (i % 3) == 0});
            if ((i % 3) == 0) begin
                chk($sformatf("held rdata cyc%0d", i), {24'd0, rdata[0]}, {24'd0, mdl_rdata[0]});
                mdl_rd[0]++;
            end
        end
        mem_read[0] = 1'b0;
        @(posedge clock);

        // Randomized mix over the filled window
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 60; i++) begin
                op = int'($urandom_range(0, 9));
                a  = 8'($urandom_range(0, 63));
                if (op == 0)      do_txn(d, 1'b1, 1'b1, a, 8'($urandom));
                else if (op < 5)  do_txn(d, 1'b0, 1'b1, a, 8'($urandom));
                else              do_txn(d, 1'b1, 1'b0, a, 8'($urandom));
            end
        end

`ifdef MEM_RESP_STATS_EN
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d rd_count", d), {16'd0, rd_count[d]}, 32'(mdl_rd[d]));
            chk($sformatf("d%0d wr_count", d), {16'd0, wr_count[d]}, 32'(mdl_wr[d]));
        end
        rst_dut(1);
        do_txn(1, 1'b0, 1'b1, 8'h01, 8'h11);
        do_txn(1, 1'b0, 1'b1, 8'h02, 8'h22);
        do_txn(1, 1'b1, 1'b0, 8'h01, 8'h00);
        do_txn(1, 1'b1, 1'b1, 8'h03, 8'h33);
        do_txn(1, 1'b0, 1'b1, 8'h03, 8'h44);
        do_txn(1, 1'b1, 1'b0, 8'h02, 8'h00);
        chk("stats wr_count", {16'd0, wr_count[1]}, 32'd3);
        chk("stats rd_count", {16'd0, rd_count[1]}, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
